core_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I core; sequences fetch, decode, execute, memory and writeback around the instruction decoder, register file, ALU and PC.
- Owns the instruction register that feeds the decoder and the valid/ready handshakes to instruction and data memory.
- Generates register-file write and PC-update strobes, plus cycle/instret counters and a bus-timeout fault.

---
 rtl/core_pkg.sv | 24 ++
 rtl/bus_watchdog.sv | 29 ++
 rtl/core_sequencer.sv | 114 +++++++++++
 tb/tb_core_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I core: sequencer states,
// reset instruction and the writeback-select codes agreed with the decoder.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // addi x0,x0,0
  localparam logic [31:0] CORE_NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_MEM  = 2'd2;
  localparam logic [1:0] WB_PC4  = 2'd3;

endpackage

// File: rtl/bus_watchdog.sv
// Wait-cycle counter shared by the fetch and data-memory requests; flags when a
// request has waited TIMEOUT-1 cycles and is still not served.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  assign expired = waiting && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (waiting && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/exec/mem/wb sequencing,
// instruction register, memory handshakes, strobes, counters and bus-timeout fault.
module core_sequencer
  import core_pkg::*;
#(
  parameter int          CNT_W    = 32,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_INSN = CORE_NOP_INSN
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  input  logic             dec_mem,
  input  logic             dec_mem_read,
  input  logic             dec_branch,
  input  logic [1:0]       dec_wb,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             pc_en,
  output logic             pc_sel_target,
  input  logic             halt,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  state_t           r_state;
  logic [31:0]      r_ir;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;
  logic             r_bus_err;

  logic w_in_fetch, w_in_mem, w_in_wb;
  logic w_waiting, w_clear, w_expired;

  assign w_in_fetch = (r_state == S_FETCH);
  assign w_in_mem   = (r_state == S_MEM);
  assign w_in_wb    = (r_state == S_WB);

  // Holding the counter clear outside FETCH/MEM gives a fresh count on every entry.
  assign w_waiting = (w_in_fetch && !imem_ready) || (w_in_mem && !dmem_ready);
  assign w_clear   = !(w_in_fetch || w_in_mem);

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_bus_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .waiting (w_waiting),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= NOP_INSN;
      r_cycle   <= '0;
      r_instret <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state != S_IDLE) r_cycle <= r_cycle + CNT_W'(1);
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_state <= S_DECODE;
          end else if (w_expired) begin
            r_state   <= S_FAULT;
            r_bus_err <= 1'b1;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC:   r_state <= dec_mem ? S_MEM : S_WB;
        S_MEM: begin
          if (dmem_ready) begin
            r_state <= S_WB;
          end else if (w_expired) begin
            r_state   <= S_FAULT;
            r_bus_err <= 1'b1;
          end
        end
        S_WB: begin
          r_instret <= r_instret + CNT_W'(1);
          r_state   <= halt ? S_HALT : S_FETCH;
        end
        S_HALT:   if (!halt) r_state <= S_FETCH;
        S_FAULT:  r_state <= S_FAULT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req      = w_in_fetch;
  assign dmem_req      = w_in_mem;
  assign dmem_we       = w_in_mem && !dec_mem_read;
  assign rf_we         = w_in_wb && (dec_wb != WB_NONE) && !(dec_mem && !dec_mem_read);
  assign pc_en         = w_in_wb;
  assign pc_sel_target = w_in_wb && dec_branch && br_taken;
  assign halted        = (r_state == S_HALT);
  assign bus_err       = r_bus_err;
  assign state         = r_state;
  assign ir            = r_ir;
  assign cycle_count   = r_cycle;
  assign instret_count = r_instret;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: instruction-level records (table + random) with
// expected latency/strobe counts, plus hand sequences for halt, timeout and reset.
module tb_core_sequencer;

  logic        clk, rst_n;
  logic        imem_req, imem_ready;
  logic [31:0] imem_rdata, ir;
  logic        dec_mem, dec_mem_read, dec_branch, br_taken;
  logic [1:0]  dec_wb;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        rf_we, pc_en, pc_sel_target;
  logic        halt, halted, bus_err;
  logic [2:0]  state;
  logic [31:0] cycle_count, instret_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          mem, rd, br, tk;
    bit [1:0]    wb;
    int          wf, wm;
    logic [31:0] insn;
    int          e_cyc;
    bit          e_rf, e_sel;
    int          e_dwe;
  } vec_t;

  core_sequencer #(.CNT_W(32), .TIMEOUT(16), .NOP_INSN(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ir(ir),
    .dec_mem(dec_mem), .dec_mem_read(dec_mem_read), .dec_branch(dec_branch),
    .dec_wb(dec_wb), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc_en(pc_en), .pc_sel_target(pc_sel_target),
    .halt(halt), .halted(halted), .bus_err(bus_err), .state(state),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: instruction-level cost and strobe outcome from the sequencing rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_cyc = 4 + v.wf + (v.mem ? v.wm + 1 : 0);
    r.e_rf  = (v.wb != 2'd0) && !(v.mem && !v.rd);
    r.e_sel = v.br && v.tk;
    r.e_dwe = (v.mem && !v.rd) ? v.wm + 1 : 0;
    return r;
  endfunction

  // Entered at the negedge of a first FETCH cycle; returns at the negedge after WB.
  task automatic run_insn(input vec_t v, input bit halt_exec, input string tag);
    int cyc = 0, fseen = 0, mseen = 0, ireq_n = 0, dreq_n = 0, dwe_n = 0, rf_n = 0, pc_n = 0;
    logic rf_wb = 0, sel_wb = 0;
    logic [31:0] ir_wb = '0, c0, i0;
    bit done = 0;
    c0 = cycle_count;
    i0 = instret_count;
    dec_mem = v.mem; dec_mem_read = v.rd; dec_branch = v.br; br_taken = v.tk; dec_wb = v.wb;
    halt = 1'b0;
    while (!done && cyc < 100) begin
      cyc++;
      if (imem_req) begin
        ireq_n++;
        imem_ready = (fseen == v.wf);
        imem_rdata = imem_ready ? v.insn : $urandom;
        fseen++;
      end else begin
        imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
      end
      if (dmem_req) begin
        dreq_n++;
        dmem_ready = (mseen == v.wm);
        mseen++;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
      end
      if (dmem_we) dwe_n++;
      if (rf_we) rf_n++;
      if (pc_en) begin
        pc_n++;
        rf_wb  = rf_we;
        sel_wb = pc_sel_target;
        ir_wb  = ir;
        done   = 1;
      end
      if (halt_exec && state == 3'd3) halt = 1'b1;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check($sformatf("%s_wb_reached", tag), 32'(done), 32'd1);
    check($sformatf("%s_cycles", tag), cyc, v.e_cyc);
    check($sformatf("%s_imem_req_cycles", tag), ireq_n, v.wf + 1);
    check($sformatf("%s_dmem_req_cycles", tag), dreq_n, v.mem ? v.wm + 1 : 0);
    check($sformatf("%s_dmem_we_cycles", tag), dwe_n, v.e_dwe);
    check($sformatf("%s_rf_we_cycles", tag), rf_n, 32'(v.e_rf));
    check($sformatf("%s_pc_en_cycles", tag), pc_n, 1);
    check($sformatf("%s_rf_we_wb", tag), rf_wb, v.e_rf);
    check($sformatf("%s_pc_sel_wb", tag), sel_wb, v.e_sel);
    check($sformatf("%s_ir", tag), ir_wb, v.insn);
    check($sformatf("%s_instret", tag), instret_count - i0, 1);
    check($sformatf("%s_cycle_delta", tag), cycle_count - c0, cyc);
    check($sformatf("%s_bus_err", tag), bus_err, 0);
    check($sformatf("%s_next_state", tag), state, halt_exec ? 3'd6 : 3'd1);
  endtask

  vec_t tbl[9];
  vec_t rv;
  logic [2:0]  exp_st[5];
  logic [31:0] c_snap;
  int n;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 2'd1, 0, 0, 32'h0050_0093, 4, 1, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 2'd2, 0, 3, 32'h0000_a103, 8, 1, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 2'd0, 0, 0, 32'h0020_a023, 5, 0, 0, 1};
    tbl[3] = '{0, 0, 1, 1, 2'd0, 0, 0, 32'h0020_8463, 4, 0, 1, 0};
    tbl[4] = '{0, 0, 1, 0, 2'd0, 0, 0, 32'h0020_8463, 4, 0, 0, 0};
    tbl[5] = '{0, 0, 1, 1, 2'd3, 1, 0, 32'h0080_00ef, 5, 1, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 2'd1, 15, 0, 32'h0010_0113, 19, 1, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 2'd0, 0, 15, 32'h0030_a223, 20, 0, 0, 16};
    tbl[8] = '{1, 0, 0, 0, 2'd1, 2, 1, 32'h0040_a423, 8, 0, 0, 2};
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
    dec_mem = 1'b0; dec_mem_read = 1'b0; dec_branch = 1'b0; br_taken = 1'b0;
    dec_wb = 2'd0; halt = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_state", state, 3'd0);
    check("rst_ir", ir, 32'h0000_0013);
    check("rst_cycle", cycle_count, 0);
    check("rst_instret", instret_count, 0);
    check("rst_strobes", {imem_req, dmem_req, dmem_we, rf_we, pc_en, halted, bus_err}, 0);

    // First instruction straight out of reset, zero-wait fetch.
    imem_ready = 1'b1; imem_rdata = 32'h0050_0093; dec_wb = 2'd1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("boot_state_c%0d", c), state, exp_st[c]);
      check($sformatf("boot_rf_we_c%0d", c), rf_we, (c == 4) ? 1 : 0);
      if (c == 4) imem_ready = 1'b0;
      @(negedge clk);
    end
    check("boot_refetch", state, 3'd1);
    check("boot_instret", instret_count, 1);
    check("boot_cycle", cycle_count, 4);
    check("boot_ir", ir, 32'h0050_0093);

    for (int i = 0; i < 9; i++) run_insn(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // halt raised during EXEC: instruction retires, then HALT.
    run_insn(tbl[0], 1'b1, "halt");
    check("halt_halted", halted, 1);
    check("halt_no_req", {imem_req, dmem_req, rf_we, pc_en}, 0);
    c_snap = cycle_count;
    repeat (3) @(negedge clk);
    check("halt_stays", state, 3'd6);
    check("halt_cycle_runs", cycle_count - c_snap, 3);
    halt = 1'b0;
    @(negedge clk);
    check("halt_release", state, 3'd1);
    check("halt_release_halted", halted, 0);

    for (int i = 0; i < 40; i++) begin
      rv.mem  = 1'($urandom_range(0, 1));
      rv.rd   = 1'($urandom_range(0, 1));
      rv.br   = 1'($urandom_range(0, 1));
      rv.tk   = 1'($urandom_range(0, 1));
      rv.wb   = 2'($urandom_range(0, 3));
      rv.wf   = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
      rv.wm   = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4));
      rv.insn = $urandom;
      run_insn(model(rv), 1'b0, $sformatf("rnd%0d", i));
    end

    // Fetch never served: 16 request cycles, then sticky FAULT.
    imem_ready = 1'b0;
    n = 0;
    while (state == 3'd1 && n < 40) begin
      if (imem_req) n++;
      @(negedge clk);
    end
    check("to_req_cycles", n, 16);
    check("to_state", state, 3'd7);
    check("to_bus_err", bus_err, 1);
    c_snap = cycle_count;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("to_stuck", state, 3'd7);
    check("to_stuck_err", bus_err, 1);
    check("to_quiet", {imem_req, dmem_req, dmem_we, rf_we, pc_en}, 0);
    check("to_cycle_runs", cycle_count - c_snap, 3);
    rst_n = 1'b0;
    #1;
    check("to_rst_state", state, 3'd0);
    check("to_rst_err", bus_err, 0);
    check("to_rst_cycle", cycle_count, 0);
    check("to_rst_ir", ir, 32'h0000_0013);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("to_restart", state, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
